// File: rtl/nano_pkg.sv
// Shared types and helpers for the nanoprocessor control unit, datapath and ALU.
package nano_pkg;

  localparam int unsigned OPW = 4;  // opcode field width (upper bits of the instruction byte)
  localparam int unsigned DW  = 8;  // data and address bus width

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpXor  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpAdd  = 4'h4,
    OpAdc  = 4'h5,
    OpSub  = 4'h6,
    OpSbc  = 4'h7,
    OpRol  = 4'h8,
    OpRor  = 4'h9,
    OpLda  = 4'hA,
    OpSta  = 4'hB,
    OpJmp  = 4'hC,
    OpJc   = 4'hD,
    OpJz   = 4'hE,
    OpHalt = 4'hF
  } opcode_t;

  // ALU function codes match the opcodes of the ALU instructions; the two
  // pass-through functions reuse codes that never reach the ALU as opcodes.
  typedef enum logic [3:0] {
    AluPass  = 4'h0,
    AluXor   = 4'h1,
    AluAnd   = 4'h2,
    AluOr    = 4'h3,
    AluAdd   = 4'h4,
    AluAdc   = 4'h5,
    AluSub   = 4'h6,
    AluSbc   = 4'h7,
    AluRol   = 4'h8,
    AluRor   = 4'h9,
    AluPassB = 4'hA
  } alu_op_t;

  typedef enum logic [2:0] {
    StFetchOp,
    StLoadOp,
    StLoadArg,
    StMemRd,
    StExec,
    StStore,
    StHalt
  } state_t;

  // Memory address mux select.
  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_R  = 1'b1;

  // Instruction class, exactly one of the first eight bits is set.
  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic jump;
    logic cond_c;
    logic cond_z;
    logic nop;
    logic halt;
    logic upd_c;  // instruction updates the carry flag
  } op_class_t;

  function automatic logic is_alu(opcode_t op);
    return (op >= OpXor) && (op <= OpRor);
  endfunction

  function automatic logic is_flag_op(opcode_t op);
    return (op >= OpAdd) && (op <= OpRor);
  endfunction

endpackage

// File: rtl/nano_if.sv
// Control bus between the nano_ctrl FSM (master) and the datapath (slave).
interface nano_if;
  import nano_pkg::*;

  logic [OPW-1:0] opcode;
  logic           carry;
  logic           zero;
  logic           run;
  logic           inc_PC;
  logic           load_PC;
  logic           load_I;
  logic           load_R;
  logic           load_ACC;
  logic           load_C;
  logic           addr_sel;
  alu_op_t        alu_op;
  logic           mem_we;
  logic           halted;

  modport master (
    input  opcode, carry, zero, run,
    output inc_PC, load_PC, load_I, load_R, load_ACC, load_C, addr_sel, alu_op, mem_we, halted
  );

  modport slave (
    output opcode, carry, zero, run,
    input  inc_PC, load_PC, load_I, load_R, load_ACC, load_C, addr_sel, alu_op, mem_we, halted
  );

endinterface

// File: rtl/nano_decode.sv
// Opcode to instruction-class decoder; the FSM only looks at these class bits.
module nano_decode import nano_pkg::*; (
  input  logic [OPW-1:0] opcode,
  output op_class_t      cls,
  output alu_op_t        alu_op
);

  opcode_t op;

  // Classify the opcode and pick the ALU function used in EXEC.
  always_comb begin
    op         = opcode_t'(opcode);
    cls        = '0;
    cls.alu    = is_alu(op);
    cls.load   = (op == OpLda);
    cls.store  = (op == OpSta);
    cls.jump   = (op == OpJmp);
    cls.cond_c = (op == OpJc);
    cls.cond_z = (op == OpJz);
    cls.nop    = (op == OpNop);
    cls.halt   = (op == OpHalt);
    cls.upd_c  = is_flag_op(op);
    if (cls.alu) begin
      alu_op = alu_op_t'(opcode);
    end else if (cls.load) begin
      alu_op = AluPassB;
    end else begin
      alu_op = AluPass;
    end
  end

endmodule

// File: rtl/nano_ctrl.sv
// Nanoprocessor control FSM: fetch, operand fetch, execute and write-back sequencing.
module nano_ctrl import nano_pkg::*; (
  input logic   clk,
  input logic   reset_n,
  nano_if.master bus
);

  state_t    state_q, state_d;
  op_class_t cls;
  alu_op_t   dec_alu_op;

  nano_decode u_decode (
    .opcode (bus.opcode),
    .cls    (cls),
    .alu_op (dec_alu_op)
  );

  // State register; reset parks the FSM in FETCH_OP so every strobe drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetchOp;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes, decoded straight from the state register.
  always_comb begin
    state_d      = state_q;
    bus.inc_PC   = 1'b0;
    bus.load_PC  = 1'b0;
    bus.load_I   = 1'b0;
    bus.load_R   = 1'b0;
    bus.load_ACC = 1'b0;
    bus.load_C   = 1'b0;
    bus.addr_sel = ADDR_PC;
    bus.alu_op   = AluPass;
    bus.mem_we   = 1'b0;
    bus.halted   = 1'b0;
    case (state_q)
      StFetchOp: begin
        if (bus.run) begin
          bus.inc_PC = 1'b1;
          state_d    = StLoadOp;
        end
      end
      StLoadOp: begin
        // inc_PC here issues the operand read while IR captures the opcode.
        bus.load_I = 1'b1;
        bus.inc_PC = 1'b1;
        state_d    = StLoadArg;
      end
      StLoadArg: begin
        state_d = StFetchOp;
        unique case (1'b1)
          cls.alu, cls.load: begin
            bus.load_R = 1'b1;
            state_d    = StMemRd;
          end
          cls.store: begin
            bus.load_R = 1'b1;
            state_d    = StStore;
          end
          cls.jump:   bus.load_PC = 1'b1;
          cls.cond_c: bus.load_PC = bus.carry;
          cls.cond_z: bus.load_PC = bus.zero;
          cls.halt:   state_d     = StHalt;
          cls.nop:    state_d     = StFetchOp;
          default:    state_d     = StFetchOp;
        endcase
      end
      StMemRd: begin
        bus.addr_sel = ADDR_R;
        state_d      = StExec;
      end
      StExec: begin
        bus.load_ACC = 1'b1;
        bus.load_C   = cls.upd_c;
        bus.alu_op   = dec_alu_op;
        state_d      = StFetchOp;
      end
      StStore: begin
        bus.addr_sel = ADDR_R;
        bus.mem_we   = 1'b1;
        state_d      = StFetchOp;
      end
      StHalt: begin
        bus.halted = 1'b1;
        state_d    = StHalt;
      end
      default: state_d = StFetchOp;
    endcase
  end

endmodule

// File: tb/tb_nano_ctrl.sv
// Bench for nano_ctrl: behavioural datapath + RAM around the FSM, per-cycle strobe scoreboard.
module tb_nano_ctrl;
  import nano_pkg::*;

  // Strobe vector bits: {inc_PC, load_PC, load_I, load_R, load_ACC, load_C, addr_sel, mem_we,
  // halted, alu_op[3:0]}
  localparam logic [12:0] S_INC   = 13'h1000;
  localparam logic [12:0] S_LDPC  = 13'h0800;
  localparam logic [12:0] S_LDI   = 13'h0400;
  localparam logic [12:0] S_LDR   = 13'h0200;
  localparam logic [12:0] S_LDACC = 13'h0100;
  localparam logic [12:0] S_LDC   = 13'h0080;
  localparam logic [12:0] S_ASEL  = 13'h0040;
  localparam logic [12:0] S_WE    = 13'h0020;
  localparam logic [12:0] S_HALT  = 13'h0010;

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  logic clk;
  logic reset_n;
  nano_if bus ();

  nano_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Datapath / RAM model
  logic [DW-1:0] init_mem [2**DW];
  logic [DW-1:0] mem [2**DW];
  logic [7:0]    pc, ir, r, acc, rdata;
  logic          c;
  logic          init_done = 1'b0;
  logic [8:0]    alu_res;
  logic [12:0]   obs;

  function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic ci);
    case (op)
      4'h1:    return {ci, a ^ b};
      4'h2:    return {ci, a & b};
      4'h3:    return {ci, a | b};
      4'h4:    return {1'b0, a} + {1'b0, b};
      4'h5:    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
      4'hA:    return {ci, b};
      default: return {ci, a};
    endcase
  endfunction

  assign alu_res    = alu(bus.alu_op, acc, rdata, c);
  assign bus.opcode = ir[7:4];
  assign bus.carry  = c;
  assign bus.zero   = (acc == 8'd0);
  assign obs = {bus.inc_PC, bus.load_PC, bus.load_I, bus.load_R, bus.load_ACC, bus.load_C,
                bus.addr_sel, bus.mem_we, bus.halted, bus.alu_op};

  always @(posedge clk) begin
    if (!init_done) begin
      mem       <= init_mem;
      pc        <= 8'd0;
      ir        <= 8'd0;
      r         <= 8'd0;
      acc       <= 8'd0;
      c         <= 1'b0;
      rdata     <= 8'd0;
      init_done <= 1'b1;
    end else begin
      rdata <= mem[bus.addr_sel ? r : pc];
      if (bus.mem_we) mem[r] <= acc;
      if (bus.inc_PC) pc <= pc + 8'd1;
      else if (bus.load_PC) pc <= rdata;
      if (bus.load_I) ir <= rdata;
      if (bus.load_R) r <= rdata;
      if (bus.load_ACC) acc <= alu_res[7:0];
      if (bus.load_C) c <= alu_res[8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [12:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic push_alu(input string n, input logic [3:0] op, input logic flag);
    push({n, ".fetch"}, S_INC);
    push({n, ".loadop"}, S_INC | S_LDI);
    push({n, ".loadarg"}, S_LDR);
    push({n, ".memrd"}, S_ASEL);
    push({n, ".exec"}, S_LDACC | (flag ? S_LDC : 13'h0) | {9'h0, op});
    push({n, ".park"}, 13'h0);
  endtask

  task automatic push_jump(input string n, input logic taken);
    push({n, ".fetch"}, S_INC);
    push({n, ".loadop"}, S_INC | S_LDI);
    push({n, ".loadarg"}, taken ? S_LDPC : 13'h0);
    push({n, ".park"}, 13'h0);
  endtask

  // Pulse run for one fetch, then wait (bounded) until every expected cycle is consumed.
  task automatic run_one();
    bus.run = 1'b1;
    @(posedge clk);
    #1 bus.run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: compare one expected strobe vector per cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, obs, mon_e.v);
      check({mon_e.tag, ".inv_pc"}, bus.inc_PC & bus.load_PC, 0);
      check({mon_e.tag, ".inv_we"}, bus.mem_we & bus.load_ACC, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 2**DW; i++) init_mem[i] = 8'h00;
    init_mem[8'h00] = 8'hA0; init_mem[8'h01] = 8'h10;  // LDA 0x10
    init_mem[8'h02] = 8'hC0; init_mem[8'h03] = 8'h40;  // JMP 0x40
    init_mem[8'h40] = 8'hD0; init_mem[8'h41] = 8'h80;  // JC 0x80 (C=0)
    init_mem[8'h42] = 8'hE0; init_mem[8'h43] = 8'h80;  // JZ 0x80 (Z=0)
    init_mem[8'h44] = 8'h40; init_mem[8'h45] = 8'h11;  // ADD 0x11 -> carry out
    init_mem[8'h46] = 8'hD0; init_mem[8'h47] = 8'h80;  // JC 0x80 (C=1)
    init_mem[8'h80] = 8'h20; init_mem[8'h81] = 8'h12;  // AND 0x12 -> zero
    init_mem[8'h82] = 8'hE0; init_mem[8'h83] = 8'h90;  // JZ 0x90 (Z=1)
    init_mem[8'h90] = 8'hB0; init_mem[8'h91] = 8'h20;  // STA 0x20
    init_mem[8'h92] = 8'h00; init_mem[8'h93] = 8'hFF;  // NOP
    init_mem[8'h94] = 8'hF0; init_mem[8'h95] = 8'h00;  // HALT
    init_mem[8'h96] = 8'hB0; init_mem[8'h97] = 8'h21;  // STA 0x21 (reset mid-store)
    init_mem[8'h10] = 8'h2A;
    init_mem[8'h11] = 8'hE0;
    init_mem[8'h12] = 8'hF0;
    init_mem[8'h20] = 8'h55;
    init_mem[8'h21] = 8'h77;

    #3 check("reset.out", obs, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    push_alu("lda", 4'hA, 1'b0);
    run_one();
    check("lda.pc", pc, 8'h02);
    check("lda.acc", acc, 8'h2A);

    push_jump("jmp", 1'b1);
    run_one();
    check("jmp.pc", pc, 8'h40);

    push_jump("jc0", 1'b0);
    run_one();
    check("jc0.pc", pc, 8'h42);

    push_jump("jz0", 1'b0);
    run_one();
    check("jz0.pc", pc, 8'h44);

    push_alu("add", 4'h4, 1'b1);
    run_one();
    check("add.acc", acc, 8'h0A);
    check("add.c", c, 1'b1);

    push_jump("jc1", 1'b1);
    run_one();
    check("jc1.pc", pc, 8'h80);

    push_alu("and", 4'h2, 1'b0);
    run_one();
    check("and.acc", acc, 8'h00);
    check("and.c", c, 1'b1);

    push_jump("jz1", 1'b1);
    run_one();
    check("jz1.pc", pc, 8'h90);

    push("sta.fetch", S_INC);
    push("sta.loadop", S_INC | S_LDI);
    push("sta.loadarg", S_LDR);
    push("sta.store", S_ASEL | S_WE);
    push("sta.park", 13'h0);
    run_one();
    check("sta.mem", mem[8'h20], 8'h00);
    check("sta.pc", pc, 8'h92);

    push_jump("nop", 1'b0);
    run_one();
    check("nop.pc", pc, 8'h94);

    push("halt.fetch", S_INC);
    push("halt.loadop", S_INC | S_LDI);
    push("halt.loadarg", 13'h0);
    push("halt.enter", S_HALT);
    run_one();
    for (int i = 0; i < 6; i++) begin
      push("halt.hold", S_HALT);
      bus.run = i[0];
      @(posedge clk);
      #1;
    end
    bus.run = 1'b0;
    check("halt.pc", pc, 8'h96);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2 check("async_rst.pre", obs, S_HALT);
    reset_n = 1'b0;
    #1 check("async_rst.out", obs, 0);

    // Reset released with run=1: first fetch on the next edge; then reset lands in STORE.
    @(posedge clk);
    #1;
    push("sta_rst.fetch", S_INC);
    push("sta_rst.loadop", S_INC | S_LDI);
    push("sta_rst.loadarg", S_LDR);
    reset_n = 1'b1;
    bus.run = 1'b1;
    @(posedge clk);
    #1 bus.run = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("sta_rst.drain", exp_q.size(), 0);
    check("sta_rst.we", obs, S_ASEL | S_WE);
    reset_n = 1'b0;
    #1 check("sta_rst.out", obs, 0);
    repeat (2) @(posedge clk);
    #1;
    check("sta_rst.mem", mem[8'h21], 8'h77);
    check("sta_rst.pc", pc, 8'h98);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nano_ctrl.md
Name: nano_ctrl

Overview:
- Control-unit FSM of the nanoprocessor.
- Sequences instruction fetch, operand fetch, execute and write-back by driving the PC register (inc_PC, load_PC), the instruction and operand registers, the accumulator/carry load enables, the memory address mux and the memory write strobe.
- Sits between the synchronous program/data RAM and the datapath (PC, IR, R, ACC, C, ALU).
- Pure Moore/Mealy control: it holds no data, only state.

Parameters:
- OPW, 4, opcode width (upper bits of the instruction byte)
- DW, 8, data and address bus width; fixes the operand width used in checks

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  OPW  current IR opcode field (valid from the cycle after load_I)
- carry  in  1  datapath carry flag C
- zero  in  1  ACC == 0 flag
- run  in  1  fetch enable; 0 freezes the FSM in FETCH_OP
- inc_PC  out  1  to PC: PC <= PC + 1
- load_PC  out  1  to PC: PC <= memory data bus
- load_I  out  1  IR <= memory data bus
- load_R  out  1  operand register R <= memory data bus
- load_ACC  out  1  ACC <= ALU result
- load_C  out  1  C <= ALU carry
- addr_sel  out  1  memory address: 0 = PC, 1 = R
- alu_op  out  4  ALU function, equal to the opcode during EXEC, else ALU_PASS
- mem_we  out  1  write ACC to mem[R]
- halted  out  1  FSM is in HALT

Behaviour:
- Memory has a synchronous read with 1-cycle latency: address presented in cycle N, data on the bus in N+1.
- Opcodes: 0 NOP, 1 XOR, 2 AND, 3 OR, 4 ADD, 5 ADC, 6 SUB, 7 SBC, 8 ROL, 9 ROR, A LDA, B STA, C JMP, D JC, E JZ, F HALT.
- Instruction format: every instruction is 2 bytes (opcode byte, operand byte). The NOP and HALT operands are fetched and ignored.
- States: FETCH_OP, LOAD_OP, LOAD_ARG, MEM_RD, EXEC, STORE, HALT.
- FETCH_OP:
  - addr_sel=0.
  - If run=1: inc_PC=1, go to LOAD_OP.
  - If run=0: stay, all strobes 0.
- LOAD_OP: load_I=1; addr_sel=0; inc_PC=1 (issues the operand read); go to LOAD_ARG.
- LOAD_ARG (memory data bus = operand):
  - JMP: load_PC=1, go to FETCH_OP.
  - JC: load_PC=carry; JZ: load_PC=zero. Go to FETCH_OP either way.
  - STA: load_R=1, go to STORE.
  - ALU ops or LDA: load_R=1, go to MEM_RD.
  - NOP: go to FETCH_OP.
  - HALT: go to HALT.
- MEM_RD: addr_sel=1 (issues the read of mem[R]); go to EXEC.
- EXEC: load_ACC=1; alu_op=opcode (LDA maps to ALU_PASS_B). load_C=1 only for ADD, ADC, SUB, SBC, ROL, ROR. Go to FETCH_OP.
- STORE: addr_sel=1, mem_we=1 for exactly 1 cycle; go to FETCH_OP.
- HALT: halted=1, all strobes 0. Left only by reset; run is ignored.
- Cycles per instruction:
  - ALU/LDA: 5
  - STA: 4
  - JMP/JC/JZ/NOP: 3
- Invariants: inc_PC and load_PC are never both 1. mem_we is asserted only in STORE. load_ACC is never asserted together with mem_we.
- Reset, including asynchronous assertion mid-instruction:
  - State returns to FETCH_OP.
  - All outputs 0, alu_op=ALU_PASS, halted=0.
  - No partial store completes after reset asserts.
  - First fetch happens on the first clk edge with reset_n=1 and run=1.
- Address wrap-around (PC 0xFF -> 0x00) is the PC register's responsibility. The controller still pulses inc_PC normally at 0xFF.
- run deasserted mid-instruction: the current instruction completes and the FSM parks in FETCH_OP.
- Opcode is sampled only in LOAD_ARG, EXEC and STORE, i.e. after load_I.

Decomposition:
- Package nano_pkg holds:
  - opcode_t enum (16 values above)
  - alu_op_t (including ALU_PASS and ALU_PASS_B)
  - state_t
  - ADDR_PC / ADDR_R constants
  - helper function is_alu(opcode_t)
- The datapath and ALU share this package.
- One natural combinational sub-module: nano_decode, mapping opcode to class (alu / load / store / jump / cond / nop / halt) and flag-update enable. The FSM consumes only these class bits.

Test Plan:
- Reset then run=1, program at 0x00 = "LDA 0x10" with mem[0x10]=0x2A:
  - inc_PC at cycles 1 and 2.
  - load_R at cycle 3.
  - addr_sel=1 at cycle 4.
  - load_ACC at cycle 5.
  - Next fetch at PC=0x02.
- "JMP 0x40": load_PC=1 in LOAD_ARG, no inc_PC in that cycle, next FETCH_OP with PC=0x40 after 3 cycles.
- "JC 0x80":
  - With carry=0: load_PC=0, PC continues at +2.
  - With carry=1: load_PC=1 and PC=0x80.
  - Repeat the same pair of checks for JZ using zero.
- "STA 0x20": mem_we high for exactly 1 cycle with addr_sel=1; load_ACC and load_C stay 0 for the whole instruction.
- "ADD 0x11" then "AND 0x12": load_C pulses for ADD and not for AND; alu_op equals 4 and then 2 in the respective EXEC cycles.
- HALT at 0x06:
  - halted=1 and stays 1 with run toggled.
  - reset_n pulsed low asynchronously mid-cycle gives FETCH_OP with all strobes 0 immediately, without waiting for clk.
